// File: rtl/irq_entry_sequencer.sv
// Interrupt entry/exit sequencer: captures request edges, picks the highest eligible
// priority, enters at an ID-stage safe point and tracks a nesting stack popped by uret.
module irq_entry_sequencer #(
    parameter int          NUM_IRQ    = 3,
    parameter int          NEST_DEPTH = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               id_valid,
    input  logic [31:0]        id_pc,
    input  logic               pipe_stall,
    input  logic               ex_redirect,
    input  logic               uret_ex,
    output logic               int_flush,
    output logic               int_redirect,
    output logic [31:0]        int_target,
    output logic [31:0]        epc_out,
    output logic [1:0]         cur_level,
    output logic [1:0]         nest_depth,
    output logic               uret_err
);
    localparam logic [1:0] DEPTH_MAX = 2'(NEST_DEPTH);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_ENTER} state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] edge_v;
    logic [31:0]        tgt_q, tgt_d;
    logic [31:0]        epc_q, epc_d;
    logic [1:0]         idx_q, idx_d;
    logic [1:0]         level_q, level_d;
    logic [1:0]         depth_q, depth_d;
    logic               flush_q, flush_d;
    logic               uret_err_q, uret_err_d;
    logic               push;
    logic [1:0]         top_idx;
    logic [1:0]         sel;
    logic               safe;

    logic [31:0] stk_pc_q  [NEST_DEPTH];
    logic [1:0]  stk_lvl_q [NEST_DEPTH];

    function automatic logic [1:0] hi_idx(input logic [NUM_IRQ-1:0] p);
        hi_idx = 2'd0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (p[k]) hi_idx = 2'(k);
        end
    endfunction

    function automatic logic elig_f(input logic [NUM_IRQ-1:0] p,
                                    input logic [1:0] lvl,
                                    input logic [1:0] dep);
        logic [2:0] need;
        need   = {1'b0, hi_idx(p)} + 3'd1;
        elig_f = (|p) && (need > {1'b0, lvl}) && (dep < DEPTH_MAX);
    endfunction

    assign edge_v  = irq_in & ~irq_prev_q;
    assign sel     = hi_idx(pend_q);
    assign safe    = id_valid && !pipe_stall && !ex_redirect && !uret_ex;
    assign top_idx = depth_q - 2'd1;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        tgt_d      = tgt_q;
        epc_d      = epc_q;
        idx_d      = idx_q;
        level_d    = level_q;
        depth_d    = depth_q;
        flush_d    = 1'b0;
        uret_err_d = uret_err_q;
        push       = 1'b0;

        if (state_q == S_ENTER) begin
            // uret/ex_redirect here belong to the instruction being killed
            push          = 1'b1;
            level_d       = idx_q + 2'd1;
            depth_d       = depth_q + 2'd1;
            pend_d[idx_q] = 1'b0;
            tgt_d         = '0;
        end else if (uret_ex) begin
            if (depth_q != 2'd0) begin
                level_d = stk_lvl_q[top_idx];
                depth_d = depth_q - 2'd1;
            end else begin
                uret_err_d = 1'b1;
            end
        end

        // A fresh edge in the clearing cycle keeps the request alive
        pend_d = pend_d | edge_v;

        case (state_q)
            S_RUN: begin
                if (elig_f(pend_q, level_q, depth_q)) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (safe && elig_f(pend_q, level_q, depth_q)) begin
                    tgt_d   = VEC_BASE + {28'd0, sel, 2'b00};
                    epc_d   = id_pc;
                    idx_d   = sel;
                    flush_d = 1'b1;
                    state_d = S_ENTER;
                end
            end
            S_ENTER: begin
                state_d = elig_f(pend_d, level_d, depth_d) ? S_WAIT : S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            // Sampling the lines during reset stops a held-high line from looking like an edge
            irq_prev_q <= irq_in;
            pend_q     <= '0;
            tgt_q      <= '0;
            epc_q      <= '0;
            idx_q      <= '0;
            level_q    <= '0;
            depth_q    <= '0;
            flush_q    <= 1'b0;
            uret_err_q <= 1'b0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                stk_pc_q[i]  <= '0;
                stk_lvl_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_in;
            pend_q     <= pend_d;
            tgt_q      <= tgt_d;
            epc_q      <= epc_d;
            idx_q      <= idx_d;
            level_q    <= level_d;
            depth_q    <= depth_d;
            flush_q    <= flush_d;
            uret_err_q <= uret_err_d;
            if (push) begin
                stk_pc_q[depth_q]  <= epc_q;
                stk_lvl_q[depth_q] <= level_q;
            end
        end
    end

    assign int_flush    = flush_q;
    assign int_redirect = flush_q;
    assign int_target   = tgt_q;
    assign epc_out      = (depth_q != 2'd0) ? stk_pc_q[top_idx] : 32'd0;
    assign cur_level    = level_q;
    assign nest_depth   = depth_q;
    assign uret_err     = uret_err_q;
endmodule

// File: tb/tb_irq_entry_sequencer.sv
// Directed bench for irq_entry_sequencer: entry latency, nesting, priority, stalls,
// uret handling, stack-full gating and mid-sequence reset.
module tb_irq_entry_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_in;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        pipe_stall;
    logic        ex_redirect;
    logic        uret_ex;
    logic        int_flush;
    logic        int_redirect;
    logic [31:0] int_target;
    logic [31:0] epc_out;
    logic [1:0]  cur_level;
    logic [1:0]  nest_depth;
    logic        uret_err;

    int tests_run = 0;
    int tests_failed = 0;

    irq_entry_sequencer dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .id_valid(id_valid), .id_pc(id_pc),
        .pipe_stall(pipe_stall), .ex_redirect(ex_redirect), .uret_ex(uret_ex),
        .int_flush(int_flush), .int_redirect(int_redirect), .int_target(int_target),
        .epc_out(epc_out), .cur_level(cur_level), .nest_depth(nest_depth), .uret_err(uret_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: raise line k, let the entry complete, then drop the line.
    task automatic raise_and_enter(input int k);
        irq_in[k] = 1'b1;
        repeat (4) tick();
        irq_in[k] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = '0; id_valid = 1'b1; id_pc = 32'h100;
        pipe_stall = 1'b0; ex_redirect = 1'b0; uret_ex = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tests_run++; if (int_redirect !== 1'b0) begin tests_failed++; $display("FAIL reset_redirect: got %0b want 0", int_redirect); end
        tests_run++; if (int_flush !== 1'b0) begin tests_failed++; $display("FAIL reset_flush: got %0b want 0", int_flush); end
        tests_run++; if (int_target !== 32'h0) begin tests_failed++; $display("FAIL reset_target: got %h want 0", int_target); end
        tests_run++; if (epc_out !== 32'h0) begin tests_failed++; $display("FAIL reset_epc: got %h want 0", epc_out); end
        tests_run++; if (cur_level !== 2'd0 || nest_depth !== 2'd0 || uret_err !== 1'b0) begin tests_failed++; $display("FAIL reset_state: level %0d depth %0d err %0b want 0 0 0", cur_level, nest_depth, uret_err); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic_entry();
        id_pc = 32'h100;
        irq_in[0] = 1'b1;
        tick();
        tests_run++; if (int_redirect !== 1'b0) begin tests_failed++; $display("FAIL basic_t1: redirect %0b want 0", int_redirect); end
        tick();
        tests_run++; if (int_redirect !== 1'b0) begin tests_failed++; $display("FAIL basic_t2: redirect %0b want 0", int_redirect); end
        tick();
        tests_run++; if (int_redirect !== 1'b1 || int_flush !== 1'b1) begin tests_failed++; $display("FAIL basic_t3: redirect %0b flush %0b want 1 1", int_redirect, int_flush); end
        tests_run++; if (int_target !== 32'h3000) begin tests_failed++; $display("FAIL basic_target: got %h want 3000", int_target); end
        tick();
        irq_in[0] = 1'b0;
        tests_run++; if (int_redirect !== 1'b0 || int_target !== 32'h0) begin tests_failed++; $display("FAIL basic_exit: redirect %0b target %h want 0 0", int_redirect, int_target); end
        tests_run++; if (cur_level !== 2'd1 || nest_depth !== 2'd1) begin tests_failed++; $display("FAIL basic_level: level %0d depth %0d want 1 1", cur_level, nest_depth); end
        tests_run++; if (epc_out !== 32'h100) begin tests_failed++; $display("FAIL basic_epc: got %h want 100", epc_out); end
        $display("[TB] test_basic_entry done");
    endtask

    task automatic test_stall_nest();
        id_pc = 32'h200; pipe_stall = 1'b1; irq_in[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if (int_redirect !== 1'b0) begin tests_failed++; $display("FAIL stall_cycle%0d: redirect %0b want 0", i, int_redirect); end
        end
        pipe_stall = 1'b0;
        tick();
        tests_run++; if (int_redirect !== 1'b1 || int_target !== 32'h3008) begin tests_failed++; $display("FAIL stall_enter: redirect %0b target %h want 1 3008", int_redirect, int_target); end
        tick();
        irq_in[2] = 1'b0; id_pc = 32'h280;
        tests_run++; if (cur_level !== 2'd3 || nest_depth !== 2'd2) begin tests_failed++; $display("FAIL stall_nested: level %0d depth %0d want 3 2", cur_level, nest_depth); end
        uret_ex = 1'b1;
        #1;
        tests_run++; if (epc_out !== 32'h200) begin tests_failed++; $display("FAIL stall_uret_epc: got %h want 200", epc_out); end
        tick();
        uret_ex = 1'b0;
        tests_run++; if (cur_level !== 2'd1 || nest_depth !== 2'd1 || epc_out !== 32'h100) begin tests_failed++; $display("FAIL stall_pop: level %0d depth %0d epc %h want 1 1 100", cur_level, nest_depth, epc_out); end
        uret_ex = 1'b1;
        tick();
        uret_ex = 1'b0;
        tests_run++; if (cur_level !== 2'd0 || nest_depth !== 2'd0 || epc_out !== 32'h0) begin tests_failed++; $display("FAIL stall_pop2: level %0d depth %0d epc %h want 0 0 0", cur_level, nest_depth, epc_out); end
        $display("[TB] test_stall_nest done");
    endtask

    task automatic test_priority_order();
        id_pc = 32'h300; irq_in[1:0] = 2'b11;
        repeat (3) tick();
        tests_run++; if (int_redirect !== 1'b1 || int_target !== 32'h3004) begin tests_failed++; $display("FAIL prio_first: redirect %0b target %h want 1 3004", int_redirect, int_target); end
        tick();
        irq_in[1:0] = 2'b00;
        tests_run++; if (cur_level !== 2'd2 || nest_depth !== 2'd1) begin tests_failed++; $display("FAIL prio_level: level %0d depth %0d want 2 1", cur_level, nest_depth); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (int_redirect !== 1'b0) begin tests_failed++; $display("FAIL prio_blocked%0d: redirect %0b want 0", i, int_redirect); end
        end
        id_pc = 32'h340; uret_ex = 1'b1;
        tick();
        uret_ex = 1'b0;
        tests_run++; if (cur_level !== 2'd0 || nest_depth !== 2'd0) begin tests_failed++; $display("FAIL prio_pop: level %0d depth %0d want 0 0", cur_level, nest_depth); end
        tick();
        tests_run++; if (int_redirect !== 1'b0) begin tests_failed++; $display("FAIL prio_wait: redirect %0b want 0", int_redirect); end
        tick();
        tests_run++; if (int_redirect !== 1'b1 || int_target !== 32'h3000) begin tests_failed++; $display("FAIL prio_second: redirect %0b target %h want 1 3000", int_redirect, int_target); end
        tick();
        tests_run++; if (cur_level !== 2'd1 || nest_depth !== 2'd1 || epc_out !== 32'h340) begin tests_failed++; $display("FAIL prio_second_state: level %0d depth %0d epc %h want 1 1 340", cur_level, nest_depth, epc_out); end
        uret_ex = 1'b1;
        tick();
        uret_ex = 1'b0;
        tick();
        $display("[TB] test_priority_order done");
    endtask

    task automatic test_ex_redirect_enter_uret();
        id_pc = 32'h400; irq_in[0] = 1'b1;
        repeat (2) tick();
        ex_redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++; if (int_redirect !== 1'b0) begin tests_failed++; $display("FAIL exred_cycle%0d: redirect %0b want 0", i, int_redirect); end
        end
        ex_redirect = 1'b0;
        tick();
        tests_run++; if (int_redirect !== 1'b1 || int_target !== 32'h3000) begin tests_failed++; $display("FAIL exred_enter: redirect %0b target %h want 1 3000", int_redirect, int_target); end
        uret_ex = 1'b1;
        tick();
        uret_ex = 1'b0; irq_in[0] = 1'b0;
        tests_run++; if (nest_depth !== 2'd1 || cur_level !== 2'd1 || uret_err !== 1'b0) begin tests_failed++; $display("FAIL enter_uret_ignored: depth %0d level %0d err %0b want 1 1 0", nest_depth, cur_level, uret_err); end
        tests_run++; if (epc_out !== 32'h400) begin tests_failed++; $display("FAIL enter_uret_epc: got %h want 400", epc_out); end
        uret_ex = 1'b1;
        tick();
        uret_ex = 1'b0;
        tick();
        $display("[TB] test_ex_redirect_enter_uret done");
    endtask

    task automatic test_uret_err_and_full();
        uret_ex = 1'b1;
        tick();
        uret_ex = 1'b0;
        tests_run++; if (uret_err !== 1'b1 || nest_depth !== 2'd0) begin tests_failed++; $display("FAIL uret_err: err %0b depth %0d want 1 0", uret_err, nest_depth); end
        id_pc = 32'h500;
        raise_and_enter(0);
        raise_and_enter(1);
        raise_and_enter(2);
        tests_run++; if (nest_depth !== 2'd3 || cur_level !== 2'd3) begin tests_failed++; $display("FAIL full_fill: depth %0d level %0d want 3 3", nest_depth, cur_level); end
        irq_in[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++; if (int_redirect !== 1'b0) begin tests_failed++; $display("FAIL full_blocked%0d: redirect %0b want 0", i, int_redirect); end
        end
        uret_ex = 1'b1;
        tick();
        uret_ex = 1'b0;
        tests_run++; if (nest_depth !== 2'd2 || cur_level !== 2'd2) begin tests_failed++; $display("FAIL full_pop: depth %0d level %0d want 2 2", nest_depth, cur_level); end
        repeat (2) tick();
        tests_run++; if (int_redirect !== 1'b1 || int_target !== 32'h3008) begin tests_failed++; $display("FAIL full_held_entry: redirect %0b target %h want 1 3008", int_redirect, int_target); end
        tick();
        irq_in[2] = 1'b0;
        tests_run++; if (nest_depth !== 2'd3) begin tests_failed++; $display("FAIL full_refill: depth %0d want 3", nest_depth); end
        uret_ex = 1'b1;
        repeat (3) tick();
        uret_ex = 1'b0;
        tests_run++; if (nest_depth !== 2'd0 || cur_level !== 2'd0 || uret_err !== 1'b1) begin tests_failed++; $display("FAIL full_unwind: depth %0d level %0d err %0b want 0 0 1", nest_depth, cur_level, uret_err); end
        tick();
        $display("[TB] test_uret_err_and_full done");
    endtask

    task automatic test_reset_mid();
        id_pc = 32'h600; irq_in[0] = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++; if (int_redirect !== 1'b0 || nest_depth !== 2'd0 || uret_err !== 1'b0) begin tests_failed++; $display("FAIL rst_wait: redirect %0b depth %0d err %0b want 0 0 0", int_redirect, nest_depth, uret_err); end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++; if (int_redirect !== 1'b0) begin tests_failed++; $display("FAIL rst_wait_held%0d: redirect %0b want 0", i, int_redirect); end
        end
        irq_in[0] = 1'b0;
        tick();
        irq_in[1] = 1'b1;
        repeat (3) tick();
        tests_run++; if (int_redirect !== 1'b1 || int_target !== 32'h3004) begin tests_failed++; $display("FAIL rst_pre_enter: redirect %0b target %h want 1 3004", int_redirect, int_target); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++; if (int_redirect !== 1'b0 || int_flush !== 1'b0 || int_target !== 32'h0) begin tests_failed++; $display("FAIL rst_enter_out: redirect %0b flush %0b target %h want 0 0 0", int_redirect, int_flush, int_target); end
        tests_run++; if (cur_level !== 2'd0 || nest_depth !== 2'd0 || epc_out !== 32'h0) begin tests_failed++; $display("FAIL rst_enter_state: level %0d depth %0d epc %h want 0 0 0", cur_level, nest_depth, epc_out); end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++; if (int_redirect !== 1'b0 || nest_depth !== 2'd0) begin tests_failed++; $display("FAIL rst_enter_held%0d: redirect %0b depth %0d want 0 0", i, int_redirect, nest_depth); end
        end
        irq_in = '0;
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_stall_nest();
        test_priority_order();
        test_ex_redirect_enter_uret();
        test_uret_err_and_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
